// File: rtl/tmr_pkg.sv
// Shared codes and flag indices for the 8-bit timer count sequencer.
package tmr_pkg;
  localparam logic [1:0] EDGE_STOP = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam logic [1:0] CLR_NONE  = 2'b00;
  localparam logic [1:0] CLR_A     = 2'b01;
  localparam logic [1:0] CLR_B     = 2'b10;
  localparam logic [1:0] CLR_EXT   = 2'b11;

  localparam int FLG_CMFA = 0;
  localparam int FLG_CMFB = 1;
  localparam int FLG_OVF  = 2;

  // True when the detected edge is one the selected edge mode counts.
  function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
    case (mode)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      EDGE_BOTH: edge_hit = rise | fall;
      default:   edge_hit = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/tmr_edge_sync.sv
// Multi-flop synchronizer with a history flop; emits one-cycle rise/fall strobes.
module tmr_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & hist_reg;
endmodule

// File: rtl/tmr_count_control.sv
// Timer channel count sequencer: edge-qualified TCNT, compare match A/B,
// clear policy, sticky flags and one-cycle event pulses.
module tmr_count_control
  import tmr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             counter_clock,
  input  logic [1:0]       edge_mode,
  input  logic             enable,
  input  logic [1:0]       clear_select,
  input  logic             tmri,
  input  logic [WIDTH-1:0] tcora,
  input  logic [WIDTH-1:0] tcorb,
  input  logic             tcnt_wr,
  input  logic [WIDTH-1:0] tcnt_wdata,
  input  logic [2:0]       flag_clr,
  output logic [WIDTH-1:0] tcnt,
  output logic             cmfa,
  output logic             cmfb,
  output logic             ovf,
  output logic             cma_pulse,
  output logic             cmb_pulse,
  output logic             ovf_pulse
);
  logic cc_rise, cc_fall, tmri_rise, tmri_fall;

  tmr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cc_sync (
    .clk(clk), .rst_n(rst_n), .async_in(counter_clock), .rise(cc_rise), .fall(cc_fall)
  );

  tmr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tmri_sync (
    .clk(clk), .rst_n(rst_n), .async_in(tmri), .rise(tmri_rise), .fall(tmri_fall)
  );

  // Shift register of ones: its top bit goes high once the sync chains and
  // history flops hold genuine post-reset samples, masking the reset artefact.
  logic [SYNC_STAGES:0] prime_reg;
  logic                 primed;
  assign primed = prime_reg[SYNC_STAGES];

  logic [WIDTH-1:0] tcnt_reg, tcnt_next;
  logic [2:0]       flag_reg, flag_next;
  logic [2:0]       pulse_reg, pulse_next;
  logic             count_ev, ext_clr, match_a, match_b, wrap;

  assign count_ev = primed & enable & edge_hit(edge_mode, cc_rise, cc_fall);
  assign ext_clr  = primed & (clear_select == CLR_EXT) & tmri_rise;
  assign match_a  = (tcnt_reg == tcora);
  assign match_b  = (tcnt_reg == tcorb);
  assign wrap     = (tcnt_reg == {WIDTH{1'b1}});

  always_comb begin
    tcnt_next  = tcnt_reg;
    pulse_next = '0;
    if (tcnt_wr) begin
      tcnt_next = tcnt_wdata;
    end else if (ext_clr) begin
      tcnt_next = '0;
    end else if (count_ev) begin
      pulse_next[FLG_CMFA] = match_a;
      pulse_next[FLG_CMFB] = match_b;
      pulse_next[FLG_OVF]  = wrap;
      if ((clear_select == CLR_A && match_a) || (clear_select == CLR_B && match_b))
        tcnt_next = '0;
      else
        tcnt_next = tcnt_reg + WIDTH'(1);
    end
    // Set wins over a coincident write-1-to-clear.
    flag_next = (flag_reg & ~flag_clr) | pulse_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_reg <= '0;
      tcnt_reg  <= '0;
      flag_reg  <= '0;
      pulse_reg <= '0;
    end else begin
      prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
      tcnt_reg  <= tcnt_next;
      flag_reg  <= flag_next;
      pulse_reg <= pulse_next;
    end
  end

  assign tcnt      = tcnt_reg;
  assign cmfa      = flag_reg[FLG_CMFA];
  assign cmfb      = flag_reg[FLG_CMFB];
  assign ovf       = flag_reg[FLG_OVF];
  assign cma_pulse = pulse_reg[FLG_CMFA];
  assign cmb_pulse = pulse_reg[FLG_CMFB];
  assign ovf_pulse = pulse_reg[FLG_OVF];

  logic unused_ok;
  assign unused_ok = tmri_fall;
endmodule

// File: tb/tb_tmr_count_control.sv
// Scoreboarded bench for tmr_count_control: directed scenarios then random traffic.
module tb_tmr_count_control;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       counter_clock = 1'b0;
  logic [1:0] edge_mode = 2'b00;
  logic       enable = 1'b0;
  logic [1:0] clear_select = 2'b00;
  logic       tmri = 1'b0;
  logic [7:0] tcora = 8'h00;
  logic [7:0] tcorb = 8'h00;
  logic       tcnt_wr = 1'b0;
  logic [7:0] tcnt_wdata = 8'h00;
  logic [2:0] flag_clr = 3'b000;
  logic [7:0] tcnt;
  logic       cmfa, cmfb, ovf, cma_pulse, cmb_pulse, ovf_pulse;

  always #5 clk = ~clk;

  tmr_count_control #(.WIDTH(8), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .counter_clock(counter_clock), .edge_mode(edge_mode),
    .enable(enable), .clear_select(clear_select), .tmri(tmri), .tcora(tcora), .tcorb(tcorb),
    .tcnt_wr(tcnt_wr), .tcnt_wdata(tcnt_wdata), .flag_clr(flag_clr), .tcnt(tcnt),
    .cmfa(cmfa), .cmfb(cmfb), .ovf(ovf),
    .cma_pulse(cma_pulse), .cmb_pulse(cmb_pulse), .ovf_pulse(ovf_pulse)
  );

  typedef struct {int t; int f; int p;} exp_t;
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Reference model: keeps every post-reset input sample; a transition between
  // samples j-1 and j takes effect S clocks after sample j was taken, and the
  // first sample after reset (compared with the reset level) never counts.
  int cc_s[$] = '{0};
  int tm_s[$] = '{0};
  int m_t = 0;
  int m_f = 0;

  initial begin
    int e, j, p, pa, pb, po;
    bit r, f, tr;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_t = 0; m_f = 0;
        cc_s.delete(); cc_s.push_back(0);
        tm_s.delete(); tm_s.push_back(0);
        sbq.push_back('{0, 0, 0});
      end else begin
        cc_s.push_back(int'(counter_clock));
        tm_s.push_back(int'(tmri));
        e = cc_s.size() - 1;
        j = e - S;
        r = 0; f = 0; tr = 0;
        if (j >= 2) begin
          r  = (cc_s[j] == 1) && (cc_s[j-1] == 0);
          f  = (cc_s[j] == 0) && (cc_s[j-1] == 1);
          tr = (tm_s[j] == 1) && (tm_s[j-1] == 0) && (clear_select == 2'b11);
        end
        p = 0;
        if (tcnt_wr) begin
          m_t = int'(tcnt_wdata);
        end else if (tr) begin
          m_t = 0;
        end else if (enable && ((edge_mode == 2'b01 && r) || (edge_mode == 2'b10 && f) ||
                                (edge_mode == 2'b11 && (r || f)))) begin
          pa = (m_t == int'(tcora)) ? 1 : 0;
          pb = (m_t == int'(tcorb)) ? 1 : 0;
          po = (m_t == 255) ? 1 : 0;
          p  = (po << 2) | (pb << 1) | pa;
          if ((clear_select == 2'b01 && pa == 1) || (clear_select == 2'b10 && pb == 1))
            m_t = 0;
          else
            m_t = (m_t + 1) % 256;
        end
        m_f = (m_f & ~int'(flag_clr) & 7) | p;
        sbq.push_back('{m_t, m_f, p});
      end
    end
  end

  // Monitor: one expected entry per clock, checked mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        n_vec++;
        if (int'(tcnt) != x.t) begin
          n_err++;
          $display("FAIL tcnt cyc %0d: got %0h want %0h", cyc, tcnt, x.t);
        end
        n_vec++;
        if (int'({ovf, cmfb, cmfa}) != x.f) begin
          n_err++;
          $display("FAIL flags cyc %0d: got %0b want %0b", cyc, {ovf, cmfb, cmfa}, x.f[2:0]);
        end
        n_vec++;
        if (int'({ovf_pulse, cmb_pulse, cma_pulse}) != x.p) begin
          n_err++;
          $display("FAIL pulses cyc %0d: got %0b want %0b", cyc,
                   {ovf_pulse, cmb_pulse, cma_pulse}, x.p[2:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int v);
    tcnt_wdata = 8'(v);
    tcnt_wr = 1'b1;
    step(1);
    tcnt_wr = 1'b0;
  endtask

  task automatic cc_set(input logic v, input int hold);
    counter_clock = v;
    step(hold);
  endtask

  task automatic spot(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  initial begin
    int cc_hold, tm_hold;
    step(3);
    do_reset();
    spot("reset_tcnt", int'(tcnt), 0);

    // Compare-A clear with a 4-clock counter_clock period.
    edge_mode = 2'b01; clear_select = 2'b01; tcora = 8'd3; enable = 1'b1;
    step(4);
    repeat (12) begin cc_set(1'b1, 2); cc_set(1'b0, 2); end
    step(S + 1);
    spot("cmpa_tcnt", int'(tcnt), 0);
    spot("cmpa_cmfa", int'(cmfa), 1);
    spot("cmpa_ovf", int'(ovf), 0);
    flag_clr = 3'b111; step(1); flag_clr = 3'b000;

    // Both-edge mode: ten transitions from zero.
    clear_select = 2'b00; wr(0); edge_mode = 2'b11;
    repeat (10) cc_set(~counter_clock, 3);
    step(S + 1);
    spot("both_tcnt", int'(tcnt), 10);

    // Overflow, then flag clear racing a new wrap, then a lone clear.
    edge_mode = 2'b01; wr(8'hFE);
    cc_set(1'b1, 3); cc_set(1'b0, 3); cc_set(1'b1, 3); cc_set(1'b0, 3);
    spot("ovf_tcnt", int'(tcnt), 0);
    spot("ovf_flag", int'(ovf), 1);
    wr(8'hFF);
    counter_clock = 1'b1; step(S);
    flag_clr = 3'b100; step(1); flag_clr = 3'b000;
    step(2);
    spot("ovf_setwins", int'(ovf), 1);
    cc_set(1'b0, 3);
    flag_clr = 3'b100; step(1); flag_clr = 3'b000;
    spot("ovf_cleared", int'(ovf), 0);

    // External clear coinciding with a count edge.
    flag_clr = 3'b111; step(1); flag_clr = 3'b000;
    clear_select = 2'b11; wr(8'h20);
    counter_clock = 1'b1; tmri = 1'b1;
    step(S + 2);
    spot("ext_tcnt", int'(tcnt), 0);
    spot("ext_flags", int'({ovf, cmfb, cmfa}), 0);
    counter_clock = 1'b0; tmri = 1'b0; step(3);

    // CPU write wins over a count that would match B.
    clear_select = 2'b10; tcorb = 8'h30; wr(8'h30);
    counter_clock = 1'b1; step(S);
    tcnt_wdata = 8'h55; tcnt_wr = 1'b1; step(1); tcnt_wr = 1'b0;
    step(2);
    spot("wr_tcnt", int'(tcnt), 8'h55);
    spot("wr_cmfb", int'(cmfb), 0);
    cc_set(1'b0, 3);

    // Reset while the input is held high, then a static enable toggle.
    clear_select = 2'b00;
    cc_set(1'b1, 4);
    do_reset();
    step(10);
    spot("rst_hold_tcnt", int'(tcnt), 0);
    enable = 1'b0; step(3); enable = 1'b1; step(6);
    spot("reen_tcnt", int'(tcnt), 0);
    cc_set(1'b0, 3); cc_set(1'b1, 3);
    step(S);
    spot("rst_first_edge", int'(tcnt), 1);

    // Random traffic.
    cc_hold = 3; tm_hold = 7;
    for (int i = 0; i < 4000; i++) begin
      if (--cc_hold == 0) begin
        counter_clock = ~counter_clock; cc_hold = $urandom_range(2, 5);
      end
      if (--tm_hold == 0) begin
        tmri = ~tmri; tm_hold = $urandom_range(3, 15);
      end
      if ($urandom_range(0, 63) == 0) begin
        edge_mode = 2'($urandom);
        enable = ($urandom_range(0, 7) != 0);
        clear_select = 2'($urandom);
      end
      if ($urandom_range(0, 31) == 0) tcora = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      if ($urandom_range(0, 31) == 0) tcorb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      tcnt_wr = ($urandom_range(0, 39) == 0);
      tcnt_wdata = 8'($urandom);
      flag_clr = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      if (i == 2000) do_reset();
      step(1);
    end
    tcnt_wr = 1'b0; flag_clr = 3'b000;
    step(S + 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tmr_count_control.md
Name: tmr_count_control

Overview:
- Per-channel count sequencer for the 8-bit timer; sits between the clock-select stage and the CPU register file.
- Takes the selected counter clock (internal prescaled tap or external TMCIn) and the edge mode, and synchronizes and edge-detects it.
- Runs TCNT, evaluates compare-match A/B against TCORA/TCORB, applies clear policy, and raises sticky flags plus one-cycle event pulses for interrupt/output logic.

Parameters:
WIDTH, 8, counter and compare register width
SYNC_STAGES, 2, synchronizer depth for counter_clock and tmri (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
counter_clock  in  1  selected count source from clock-select stage, asynchronous to clk
edge_mode  in  2  00 stop, 01 rising, 10 falling, 11 both edges
enable  in  1  count enable (CPU control bit)
clear_select  in  2  00 no clear, 01 clear on match A, 10 clear on match B, 11 clear on tmri rising edge
tmri  in  1  external counter reset input, asynchronous
tcora  in  WIDTH  compare value A
tcorb  in  WIDTH  compare value B
tcnt_wr  in  1  CPU write strobe for TCNT
tcnt_wdata  in  WIDTH  CPU write data
flag_clr  in  3  write-1-to-clear: [0] cmfa, [1] cmfb, [2] ovf
tcnt  out  WIDTH  counter value
cmfa, cmfb, ovf  out  1 each  sticky flags
cma_pulse, cmb_pulse, ovf_pulse  out  1 each  one-cycle event strobes

Behaviour:
- Reset: tcnt, all flags, all pulses, synchronizer chains, history registers and primed bit go to 0.
- Sync: counter_clock and tmri each pass through SYNC_STAGES flops plus one history flop.
- Edge event: combinational compare of the last sync stage against the history flop.
- Latency: an input transition sampled at clk edge k updates tcnt at edge k+SYNC_STAGES.
- Input constraint: counter_clock high and low times must each be >= 2 clk periods. Shorter pulses give undefined counts.
- Primed bit: set SYNC_STAGES+1 cycles after rst_n deasserts. Edge events before that are discarded, so a level already high at reset release is not counted.
- count_ev = primed & enable & (edge matches edge_mode). edge_mode 00 never counts.
- History flops track the input regardless of enable and edge_mode. Re-enabling or changing mode therefore produces no spurious edge.
- On count_ev, matches are evaluated against the current (pre-increment) tcnt:
  - match_a = (tcnt == tcora); match_b = (tcnt == tcorb).
  - wrap = (tcnt == all-ones).
- Next tcnt on count_ev:
  - 0 if (clear_select==01 & match_a) or (clear_select==10 & match_b).
  - Otherwise tcnt+1, modulo 2^WIDTH.
  - Period with compare clear is therefore TCOR+1 counts.
- Event pulses on count_ev:
  - cma_pulse = match_a and cmb_pulse = match_b, independent of clear_select.
  - ovf_pulse = wrap, including when the clear-to-0 coincides with all-ones.
  - Pulses are registered and align with the tcnt update edge.
- External clear: clear_select==11 and a synchronized tmri rising edge set tcnt to 0. No flags are set by this clear.
- Priority, high to low: rst_n, tcnt_wr, tmri clear, count_ev.
  - A lower-priority event in the same cycle is dropped entirely: no tcnt change, no pulse, no flag.
  - Example: a CPU write coinciding with a count event loads tcnt_wdata exactly.
- Flags: set by the corresponding pulse, cleared by the flag_clr bit. Simultaneous set and clear leaves the flag set.
- tcora/tcorb changes take effect at the next count_ev. No shadowing.
- Both matches true in one count_ev: both pulses fire, and clear follows clear_select.

Decomposition:
- tmr_pkg holds:
  - edge_mode codes EDGE_STOP/RISE/FALL/BOTH
  - clear_select codes CLR_NONE/CLR_A/CLR_B/CLR_EXT
  - flag index constants FLG_CMFA=0, FLG_CMFB=1, FLG_OVF=2
- One sub-module, tmr_edge_sync: parameterized SYNC_STAGES synchronizer plus history flop, outputs rise/fall strobes. Instantiated twice (counter_clock, tmri).

Test Plan:
1. Compare-A clear: edge_mode=01, clear_select=01, tcora=3, enable=1, counter_clock period 40 ns (clk 10 ns). Required: tcnt 0,1,2,3,0,1..., cma_pulse on each 3->0 update, cmfa set, ovf stays 0.
2. Both-edge mode: edge_mode=11, 10 counter_clock transitions from tcnt=0. Required: tcnt=10, each update exactly SYNC_STAGES clks after sampling.
3. Overflow and flag handshake: free run, CPU writes 0xFE, two rising edges. Required: tcnt FF then 00, single ovf_pulse, ovf=1. Then flag_clr[2] coincident with a new wrap leaves ovf=1; flag_clr[2] alone clears it.
4. External clear: clear_select=11, tcnt=0x20. Required: tmri rising edge gives tcnt=0; a count edge landing in the same cycle is dropped (tcnt=0, not 1), with no flags set.
5. Write priority: tcnt_wr with tcnt_wdata=0x55 in the same cycle as count_ev at tcnt=tcorb. Required: tcnt=0x55, no cmb_pulse, cmfb unchanged.
6. Reset mid-operation: assert rst_n low while counting with counter_clock held high, then release. Required: all outputs 0, no count until the next genuine rising edge, and enable toggling 0->1 with a static input causes no count.
